// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin 4:1 arbiter driving mux selects s1/s0.
// Optional grant timeout compiled in by MUX_SEL_ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       busy,
  output logic       tmo
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_timeout
    $error("mux_sel_arbiter: TIMEOUT out of range for CNT_W");
  end

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;

  logic       win_vld;
  logic [1:0] win;
  logic       rel_user;
  logic       rel_tmo;

  // first requester at or after ptr, wrapping mod 4
  always_comb begin
    win_vld = 1'b0;
    win     = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        win_vld = 1'b1;
        win     = ptr_q + 2'(i);
      end
    end
  end

  assign rel_user = done || !req[idx_q];

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rel_tmo = (cnt_q == CNT_W'(TIMEOUT - 1));

  // grant-length counter, cleared while idle
  always_comb begin
    cnt_d = '0;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign rel_tmo = 1'b0;
`endif

  // next state: grant in IDLE, release checks in GRANT
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = GRANT;
          idx_d   = win;
          sel_d   = win;
          gnt_d   = 4'b0001 << win;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        if (rel_user || rel_tmo) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          ptr_d   = idx_q + 2'd1;
          tmo_d   = !rel_user && rel_tmo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign s1   = sel_q[1];
  assign s0   = sel_q[0];
  assign gnt  = gnt_q;
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: scoreboard bench with a cycle-level reference model.
// Directed scenarios followed by randomized req/done traffic.
module tb_mux_sel_arbiter;

  localparam int TO = 4;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic       s1, s0, busy, tmo;
  logic [3:0] gnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] expq[$];

  int m_cur = -1;
  int m_ptr = 0;
  int m_len = 0;
  int m_sel = 0;
  bit m_tmo = 1'b0;

  mux_sel_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .req (req),
    .done(done),
    .s1  (s1),
    .s0  (s0),
    .gnt (gnt),
    .busy(busy),
    .tmo (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b (tmo,busy,s1,s0,gnt)",
               nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cur = -1;
    m_ptr = 0;
    m_len = 0;
    m_sel = 0;
    m_tmo = 1'b0;
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    logic [1:0] s;
    g = (m_cur < 0) ? 4'b0000 : 4'(1 << m_cur);
    s = 2'(m_sel);
    return {m_tmo, (m_cur >= 0), s, g};
  endfunction

  // One clock of the reference arbiter, in terms of channels and lengths
  task automatic model_step(input logic [3:0] r, input logic d);
    bit found;
    bit by_user;
    bit by_time;
    m_tmo = 1'b0;
    if (m_cur < 0) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (!found && r[c]) begin
          found = 1'b1;
          m_cur = c;
          m_sel = c;
          m_len = 1;
        end
      end
    end else begin
      by_user = d || !r[m_cur];
      by_time = TE && (m_len >= TO);
      if (by_user || by_time) begin
        m_tmo = !by_user;
        m_ptr = (m_cur + 1) % 4;
        m_cur = -1;
      end else begin
        m_len++;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    model_step(r, d);
    expq.push_back(model_out());
  endtask

  // monitor: compare DUT outputs against the queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        chk("cycle", {tmo, busy, s1, s0, gnt}, expq.pop_front());
      end
    end
  end

  initial begin
    #2;
    req = 4'b1111;
    rst = 1'b1;
    #1;
    chk("reset_async", {tmo, busy, s1, s0, gnt}, 8'h00);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b0100, 1'b0);
    step(4'b0100, 1'b1);
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b1);

    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0);
      step(4'b1111, 1'b1);
    end

    for (int i = 0; i < 24; i++) begin
      step(4'b0010, 1'b0);
    end
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);

    step(4'b0100, 1'b0);
    step(4'b0000, 1'b1);
    step(4'b1001, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0001, 1'b0);

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_mid", {tmo, busy, s1, s0, gnt}, 8'h00);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0000, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      logic [3:0] r;
      logic d;
      r = req;
      if ($urandom_range(0, 5) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 9) == 0);
      step(r, d);
    end

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
